// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation pipeline and its scheduler.
//   DATA_W / SEL_W / PIPE_DEPTH : default datapath geometry
//   angle_45 .. angle_1         : atan(2^-i) in the datapath angle format (256 LSB per degree)
//   id_width()                  : requester-ID width for a given requester count
//   rr_wrap()                   : single-step modulo used by the round-robin search
// The per-stage tag is a packed {v, id} pair; the scheduler declares it with
// its own ID width because that width follows NUM_REQ.
package cordic_pkg;

  localparam int DATA_W     = 24;
  localparam int SEL_W      = 4;
  localparam int PIPE_DEPTH = 5;

  // 24'h002d00 = 45 deg, i.e. 256 LSB per degree.
  localparam logic [DATA_W-1:0] angle_45 = 24'h002d00;  // atan(1)
  localparam logic [DATA_W-1:0] angle_26 = 24'h001a91;  // atan(1/2)
  localparam logic [DATA_W-1:0] angle_14 = 24'h000e09;  // atan(1/4)
  localparam logic [DATA_W-1:0] angle_7  = 24'h000720;  // atan(1/8)
  localparam logic [DATA_W-1:0] angle_3  = 24'h000394;  // atan(1/16)
  localparam logic [DATA_W-1:0] angle_1  = 24'h0001ca;  // atan(1/32)

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Callers guarantee 0 <= i < 2*n, so one conditional subtract is a full modulo.
  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter that owns the priority pointer.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> 0)
//   req        : per-requester request (already masked by the caller)
//   advance    : the current grant was taken; pointer moves past the winner
//   grant      : one-hot grant (zero when nothing requests)
//   grant_idx  : index of the granted requester (0 when nothing is granted)
//   any_grant  : some requester is granted this cycle
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [ID_W-1:0] ptr_q;

  // First asserted request at or after the pointer, wrapping once around.
  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_wrap(int'(ptr_q) + i, NUM_REQ);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ID_W'(rr_wrap(int'(grant_idx) + 1, NUM_REQ));
    end
  end

endmodule

// File: rtl/cordic_pipe_sched.sv
// Scheduler sharing one CORDIC rotation pipeline between NUM_REQ requesters.
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : per-requester handshake
//   req_x/req_y/req_angle/req_sel: packed operands, requester i at [i*W +: W]
//   drain                        : level, blocks new grants while high
//   dp_valid, dp_x/y/angle/sel   : granted operand set to pipeline stage 1 (zero when idle)
//   dp_reg_en                    : enable for every pipeline register
//   res_x/res_y/res_angle        : pipeline outputs
//   res_valid/res_ready, res_id  : result handshake and requester ID of the result
//   res_xo/res_yo/res_ao         : pass-through of the pipeline outputs
//   busy, drained                : occupancy != 0, drain with empty pipeline
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. req_ready never depends on anything but the request vector, stall,
// drain and the pointer; res_valid stays high with res_id/res_xo stable until
// res_ready takes it. A blocked result freezes the whole pipeline, so no
// request is accepted in a cycle where the output is stalled.
module cordic_pipe_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = cordic_pkg::DATA_W,
  parameter int SEL_W      = cordic_pkg::SEL_W,
  parameter int PIPE_DEPTH = cordic_pkg::PIPE_DEPTH,
  parameter int ID_W       = cordic_pkg::id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_angle,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  input  logic                      drain,
  output logic                      dp_valid,
  output logic [DATA_W-1:0]         dp_x,
  output logic [DATA_W-1:0]         dp_y,
  output logic [DATA_W-1:0]         dp_angle,
  output logic [SEL_W-1:0]          dp_sel,
  output logic                      dp_reg_en,
  input  logic [DATA_W-1:0]         res_x,
  input  logic [DATA_W-1:0]         res_y,
  input  logic [DATA_W-1:0]         res_angle,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [DATA_W-1:0]         res_xo,
  output logic [DATA_W-1:0]         res_yo,
  output logic [DATA_W-1:0]         res_ao,
  output logic                      busy,
  output logic                      drained
);

  localparam int OCC_W = $clog2(PIPE_DEPTH + 1);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  tag_t               tag_q [PIPE_DEPTH];
  logic [OCC_W-1:0]   occ_q;

  logic               stall;
  logic               grant_en;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               accept;
  logic               retire;

  assign res_valid = tag_q[PIPE_DEPTH-1].v;
  assign res_id    = tag_q[PIPE_DEPTH-1].id;
  assign stall     = res_valid & ~res_ready;
  assign dp_reg_en = ~stall;

  // rst gates the grant so req_ready drops the moment reset is asserted.
  assign grant_en   = ~stall & ~drain & ~rst;
  assign req_masked = req_valid & {NUM_REQ{grant_en}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_masked),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A grant is only ever given to an asserted request, so grant == accept.
  assign req_ready = grant;
  assign accept    = any_grant;
  assign retire    = res_valid & res_ready;
  assign dp_valid  = any_grant;

  always_comb begin
    dp_x     = '0;
    dp_y     = '0;
    dp_angle = '0;
    dp_sel   = '0;
    if (any_grant) begin
      dp_x     = req_x    [int'(grant_idx)*DATA_W +: DATA_W];
      dp_y     = req_y    [int'(grant_idx)*DATA_W +: DATA_W];
      dp_angle = req_angle[int'(grant_idx)*DATA_W +: DATA_W];
      dp_sel   = req_sel  [int'(grant_idx)*SEL_W  +: SEL_W];
    end
  end

  // Tags move in lockstep with the datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else if (dp_reg_en) begin
      tag_q[0].v  <= any_grant;
      tag_q[0].id <= any_grant ? grant_idx : '0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Accept needs ~stall, so with a full pipeline any accept coincides with a
  // retire and the count cannot exceed PIPE_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign busy    = (occ_q != '0);
  assign drained = drain & (occ_q == '0);

  assign res_xo = res_x;
  assign res_yo = res_y;
  assign res_ao = res_angle;

endmodule

// File: tb/tb_cordic_pipe_sched.sv
// Directed bench for cordic_pipe_sched. A plain 5-register pipeline stands in
// for the CORDIC datapath so results carry the operands that were granted.
module tb_cordic_pipe_sched;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 24;
  localparam int SEL_W      = 4;
  localparam int PIPE_DEPTH = 5;
  localparam int ID_W       = 2;
  localparam int SB_W       = ID_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_x, req_y, req_angle;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic                      drain;
  logic                      dp_valid, dp_reg_en;
  logic [DATA_W-1:0]         dp_x, dp_y, dp_angle;
  logic [SEL_W-1:0]          dp_sel;
  logic [DATA_W-1:0]         res_x, res_y, res_angle;
  logic                      res_valid, res_ready;
  logic [ID_W-1:0]           res_id;
  logic [DATA_W-1:0]         res_xo, res_yo, res_ao;
  logic                      busy, drained;

  cordic_pipe_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_angle (req_angle),
    .req_sel   (req_sel),
    .drain     (drain),
    .dp_valid  (dp_valid),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_angle  (dp_angle),
    .dp_sel    (dp_sel),
    .dp_reg_en (dp_reg_en),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_angle (res_angle),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_xo    (res_xo),
    .res_yo    (res_yo),
    .res_ao    (res_ao),
    .busy      (busy),
    .drained   (drained)
  );

  // Stand-in datapath: operands delayed by PIPE_DEPTH enabled registers.
  logic [3*DATA_W-1:0] pipe_q [PIPE_DEPTH];
  always @(posedge clk) begin
    if (dp_reg_en) begin
      pipe_q[0] <= {dp_angle, dp_y, dp_x};
      for (int k = 1; k < PIPE_DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign res_x     = pipe_q[PIPE_DEPTH-1][DATA_W-1:0];
  assign res_y     = pipe_q[PIPE_DEPTH-1][2*DATA_W-1:DATA_W];
  assign res_angle = pipe_q[PIPE_DEPTH-1][3*DATA_W-1:2*DATA_W];

  // ---------------- operands ----------------
  logic [DATA_W-1:0] op_x [NUM_REQ];
  logic [DATA_W-1:0] op_y [NUM_REQ];
  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [SEL_W-1:0]  op_s [NUM_REQ];

  // ---------------- counters / scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int n_retired   = 0;
  int n_base;
  logic [SB_W-1:0] exp_q [$];
  logic [SB_W-1:0] sb_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (res_valid && res_ready) begin
        n_retired++;
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_empty: observed result id %0d expected no result", res_id);
        end
        if (exp_q.size() != 0) begin
          sb_exp = exp_q.pop_front();
          check("sb_result", 32'({res_id, res_xo}), 32'(sb_exp));
        end
      end
      for (int g = 0; g < NUM_REQ; g++) begin
        if (req_valid[g] && req_ready[g]) exp_q.push_back({ID_W'(g), op_x[g]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    drain = 1'b0;
    res_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = '0;
    drain = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_x[i] = 24'h010000 + 24'(i) * 24'h001000;
      op_y[i] = 24'(i) * 24'h000100;
      op_a[i] = 24'h002d00 + 24'(i);
      op_s[i] = SEL_W'(i + 1);
      req_x[i*DATA_W +: DATA_W]     = op_x[i];
      req_y[i*DATA_W +: DATA_W]     = op_y[i];
      req_angle[i*DATA_W +: DATA_W] = op_a[i];
      req_sel[i*SEL_W +: SEL_W]     = op_s[i];
    end

    // Reset state, with every requester asking.
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_dp_valid",  32'(dp_valid),  32'h0);
    check("rst_dp_x",      32'(dp_x),      32'h0);
    check("rst_dp_reg_en", 32'(dp_reg_en), 32'h1);
    check("rst_drained",   32'(drained),   32'h0);

    // 1. Single op from requester 0.
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_dp_valid",  32'(dp_valid),  32'h1);
    check("t1_dp_x",      32'(dp_x),      32'h010000);
    check("t1_dp_y",      32'(dp_y),      32'h0);
    check("t1_dp_angle",  32'(dp_angle),  32'h002d00);
    check("t1_dp_sel",    32'(dp_sel),    32'h1);
    check("t1_busy_pre",  32'(busy),      32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("t1_ready_drop", 32'(req_ready), 32'h0);
    check("t1_dp_idle_x",  32'(dp_x),      32'h0);
    check("t1_busy",       32'(busy),      32'h1);
    check("t1_early",      32'(res_valid), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      #1;
      check("t1_early", 32'(res_valid), 32'h0);
    end
    @(negedge clk);
    #1;
    check("t1_res_valid", 32'(res_valid), 32'h1);
    check("t1_res_id",    32'(res_id),    32'h0);
    check("t1_res_xo",    32'(res_xo),    32'h010000);
    check("t1_res_yo",    32'(res_yo),    32'h0);
    check("t1_res_ao",    32'(res_ao),    32'h002d00);
    @(negedge clk);
    #1;
    check("t1_res_done", 32'(res_valid), 32'h0);
    check("t1_busy_end", 32'(busy),      32'h0);

    // 2 + 6. Round robin over all four, full-occupancy accept+retire.
    do_reset();
    n_base = n_retired;
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk);
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (j < 8) begin
        check("t2_grant", 32'(req_ready), 32'(4'b0001 << (j % 4)));
        check("t2_dp_x",  32'(dp_x),      32'(op_x[j % 4]));
      end
      if (j >= 5 && j <= 12) begin
        check("t2_res_valid", 32'(res_valid), 32'h1);
        check("t2_res_id",    32'(res_id),    32'((j - 5) % 4));
      end
      if (j >= 1 && j <= 12) check("t6_busy", 32'(busy), 32'h1);
      if (j == 13) begin
        check("t6_busy_end",  32'(busy),      32'h0);
        check("t2_res_done",  32'(res_valid), 32'h0);
      end
    end
    check("t2_retired", 32'(n_retired - n_base), 32'd8);

    // 3. Back-pressure on a requester-2 stream.
    n_base = n_retired;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      req_valid = (j <= 10) ? 4'b0100 : 4'b0000;
      res_ready = (j >= 5 && j <= 7) ? 1'b0 : 1'b1;
      #1;
      if (j >= 5 && j <= 7) begin
        check("t3_reg_en",    32'(dp_reg_en), 32'h0);
        check("t3_req_ready", 32'(req_ready), 32'h0);
        check("t3_dp_valid",  32'(dp_valid),  32'h0);
        check("t3_res_id",    32'(res_id),    32'h2);
        check("t3_res_xo",    32'(res_xo),    32'(op_x[2]));
      end
      if (j <= 4 || (j >= 8 && j <= 10)) begin
        check("t3_grant",  32'(req_ready), 32'h4);
        check("t3_reg_en", 32'(dp_reg_en), 32'h1);
      end
      if (j >= 8 && j <= 15) check("t3_res_valid", 32'(res_valid), 32'h1);
      if (j == 16) begin
        check("t3_res_done", 32'(res_valid), 32'h0);
        check("t3_busy_end", 32'(busy),      32'h0);
      end
    end
    check("t3_retired", 32'(n_retired - n_base), 32'd8);

    // 4. Drain with 0101 streaming; pointer is 3 on entry.
    for (int j = 0; j <= 17; j++) begin
      logic [3:0] e;
      @(negedge clk);
      req_valid = (j <= 11) ? 4'b0101 : 4'b0000;
      drain = (j >= 3 && j <= 9);
      #1;
      if (j <= 11) begin
        e = (j == 1 || j == 10) ? 4'b0100 :
            (j >= 3 && j <= 9)  ? 4'b0000 : 4'b0001;
        check("t4_grant", 32'(req_ready), 32'(e));
      end
      if (j >= 3 && j <= 7) check("t4_not_drained", 32'(drained), 32'h0);
      if (j == 8 || j == 9) begin
        check("t4_drained", 32'(drained), 32'h1);
        check("t4_idle",    32'(busy),    32'h0);
      end
      if (j == 10) check("t4_drained_off", 32'(drained), 32'h0);
      if (j == 17) check("t4_busy_end", 32'(busy), 32'h0);
    end

    // 5. Asynchronous reset with the oldest op at the output; pointer is 1.
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      check("t5_grant", 32'(req_ready), 32'(4'b0001 << ((j + 1) % 4)));
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("t5_pre_valid", 32'(res_valid), 32'h1);
    check("t5_pre_id",    32'(res_id),    32'h1);
    check("t5_pre_busy",  32'(busy),      32'h1);
    #1;
    rst = 1'b1;
    req_valid = 4'b1111;
    exp_q.delete();
    #1;
    check("t5_res_valid", 32'(res_valid), 32'h0);
    check("t5_busy",      32'(busy),      32'h0);
    check("t5_req_ready", 32'(req_ready), 32'h0);
    check("t5_dp_valid",  32'(dp_valid),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ptr_zero", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    for (int j = 0; j < 6; j++) @(negedge clk);
    #1;
    check("t5_busy_end", 32'(busy), 32'h0);
    check("sb_leftover", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
